fb_write_stage: RTL and testbench
=================================

FB_WRITE_STAGE -- requirements
Module: fb_write_stage

Interface
- REQ-001 Parameter FIFO_DEPTH, default 8, pixel-write FIFO entries, power of two.
- REQ-002 Parameter FB_WIDTH, default 640, frame width in pixels; also the row stride.
- REQ-003 Parameter FB_HEIGHT, default 480, frame height in pixels.
- REQ-004 clk_clk  in  1  sole clock; all logic on rising edge.
- REQ-005 reset_reset_n  in  1  asynchronous, active-low reset.
- REQ-006 program_x  in  10  pixel column from the copy engine.
- REQ-007 program_y  in  10  pixel row from the copy engine.
- REQ-008 program_data  in  16  pixel word.
- REQ-009 program_write  in  1  one-cycle write strobe qualifying x/y/data.
- REQ-010 fb_sel  in  1  target frame buffer: 0 selects base 0x00000, 1 selects base 0x80000; sampled at FIFO push.
- REQ-011 sram_grant  in  1  high while this block may start an SRAM write cycle.
- REQ-012 ovf_clear  in  1  one-cycle pulse that clears overflow.
- REQ-013 sram_addr  out  20  SRAM word address.
- REQ-014 sram_dq_out  out  16  SRAM write data.
- REQ-015 sram_dq_oe  out  1  high while this block drives the SRAM data bus.
- REQ-016 sram_we_n, sram_ce_n  out  1 each  active-low SRAM controls.
- REQ-017 fifo_full, overflow, busy  out  1 each  FIFO full; sticky dropped-write flag; FIFO non-empty or FSM not IDLE.

Function
- REQ-018 program_write high with in-range coordinates (x < FB_WIDTH, y < FB_HEIGHT) and FIFO not full (judged on the pre-edge count) SHALL push {fb_sel, x, y, data}.
- REQ-019 Out-of-range writes SHALL be discarded silently, with no push and no overflow.
- REQ-020 A push attempt while full SHALL be dropped and SHALL set overflow, even if a pop occurs in the same cycle.
- REQ-021 ovf_clear SHALL clear overflow; if ovf_clear and a drop occur in the same cycle, set wins.
- REQ-022 The FSM SHALL have states IDLE, SETUP, WRITE, HOLD.
  - IDLE->SETUP: FIFO non-empty and sram_grant=1; pops the head.
  - SETUP->WRITE unconditional.
  - WRITE->HOLD unconditional.
  - HOLD->SETUP if FIFO non-empty and sram_grant=1 (pop); otherwise HOLD->IDLE.
- REQ-023 On SETUP entry, sram_addr SHALL be registered as {fb_sel, 19'(y*FB_WIDTH + x)} and sram_dq_out as data.
- REQ-024 sram_addr and sram_dq_out SHALL then stay stable through SETUP, WRITE and HOLD.
- REQ-025 sram_ce_n=0 and sram_dq_oe=1 SHALL hold in SETUP, WRITE and HOLD.
- REQ-026 sram_we_n=0 SHALL hold only in WRITE.
- REQ-027 Latency: for a push at edge E0 into an empty FIFO with grant high, the FSM SHALL be in SETUP after E1 and WRITE after E2, with sram_we_n low for exactly one cycle.
- REQ-028 Sustained throughput SHALL be one pixel per 3 cycles.
- REQ-029 sram_grant falling mid-cycle SHALL NOT abort the cycle in progress; it only blocks the next SETUP.
- REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
- REQ-031 fifo_full SHALL be high exactly when count == FIFO_DEPTH.
- REQ-032 A simultaneous push and pop at count == FIFO_DEPTH-1 or lower SHALL leave the count unchanged.

Reset
- REQ-033 Asserting reset_reset_n low SHALL immediately force: FSM=IDLE, FIFO empty, sram_we_n=1, sram_ce_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0, fifo_full=0, overflow=0, busy=0.
- REQ-034 A reset during WRITE SHALL abort the cycle with sram_we_n going high asynchronously, and no queued entry SHALL survive.

Configuration
- REQ-035 With macro FB_TRANSPARENCY_EN defined, a program_write whose program_data == 16'hF81F SHALL be discarded at input: no push, no overflow.
- REQ-036 Without FB_TRANSPARENCY_EN, 16'hF81F SHALL be written like any other value.

Verification
- REQ-037 Single write x=3, y=2, data=16'h1234, fb_sel=0, grant=1 -> sram_addr=0x00503, sram_dq_out=16'h1234, sram_we_n low for exactly 1 cycle, 2 edges after the push.
- REQ-038 x=639, y=479, fb_sel=1 -> sram_addr=0xCAFFF; x=640, y=0 -> no SRAM cycle, overflow stays 0.
- REQ-039 grant=0, 9 consecutive writes -> fifo_full=1 after 8, overflow=1, no SRAM activity; then grant=1 -> exactly 8 writes, 3 cycles apart, in push order.
- REQ-040 ovf_clear pulsed in the same cycle as a drop -> overflow stays 1; pulsed alone next cycle -> overflow=0.
- REQ-041 reset_reset_n low while sram_we_n=0 -> sram_we_n=1 and busy=0 before the next clock edge; no SRAM cycle after release until a new push.
- REQ-042 FB_TRANSPARENCY_EN defined, data=16'hF81F -> no SRAM cycle; macro undefined -> normal write of 16'hF81F.

Source files
------------

// File: rtl/fb_write_if.sv
// Pixel-write and SRAM-side signal bundle for fb_write_stage.
// master = copy engine / SRAM arbiter side, slave = fb_write_stage.
interface fb_write_if;
    logic [9:0]  program_x;
    logic [9:0]  program_y;
    logic [15:0] program_data;
    logic        program_write;
    logic        fb_sel;
    logic        sram_grant;
    logic        ovf_clear;
    logic [19:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic        sram_we_n;
    logic        sram_ce_n;
    logic        fifo_full;
    logic        overflow;
    logic        busy;

    modport master (
        output program_x, program_y, program_data, program_write,
        output fb_sel, sram_grant, ovf_clear,
        input  sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_ce_n,
        input  fifo_full, overflow, busy
    );

    modport slave (
        input  program_x, program_y, program_data, program_write,
        input  fb_sel, sram_grant, ovf_clear,
        output sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_ce_n,
        output fifo_full, overflow, busy
    );
endinterface

// File: rtl/fb_write_stage.sv
// Frame-buffer write stage: queues pixel writes in a FIFO and replays them as
// 3-cycle SRAM write cycles. Define FB_TRANSPARENCY_EN to drop 16'hF81F pixels.
module fb_write_stage #(
    parameter int FIFO_DEPTH = 8,
    parameter int FB_WIDTH   = 640,
    parameter int FB_HEIGHT  = 480
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    fb_write_if.slave  bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [10:0]      X_LIM     = 11'(FB_WIDTH);
    localparam logic [10:0]      Y_LIM     = 11'(FB_HEIGHT);
    localparam logic [18:0]      STRIDE    = 19'(FB_WIDTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    typedef struct packed {
        logic        fb;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [15:0] data;
    } entry_t;

    localparam entry_t ENTRY_ZERO = entry_t'({$bits(entry_t){1'b0}});

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    entry_t           mem_q [FIFO_DEPTH];
    entry_t           mem_d [FIFO_DEPTH];
    logic             overflow_q, overflow_d;
    logic [19:0]      sram_addr_q, sram_addr_d;
    logic [15:0]      sram_dq_out_q, sram_dq_out_d;
    logic             sram_we_n_q, sram_we_n_d;
    logic             sram_ce_n_q, sram_ce_n_d;
    logic             sram_dq_oe_q, sram_dq_oe_d;
    logic             fifo_full_q, fifo_full_d;
    logic             busy_q, busy_d;

    logic             in_range_s;
    logic             transparent_s;
    logic             push_req_s;
    logic             push_s;
    logic             drop_s;
    logic             pop_s;
    logic             full_s;
    logic             empty_s;
    entry_t           head_s;
    logic [18:0]      lin_addr_s;

    // Input qualification, FIFO push/pop decisions and the linear address of the head entry.
    always_comb begin
        in_range_s = ({1'b0, bus.program_x} < X_LIM) && ({1'b0, bus.program_y} < Y_LIM);
`ifdef FB_TRANSPARENCY_EN
        transparent_s = (bus.program_data == 16'hF81F);
`else
        transparent_s = 1'b0;
`endif
        push_req_s = bus.program_write && in_range_s && !transparent_s;
        full_s     = (count_q == DEPTH_C);
        empty_s    = (count_q == CNT_ZERO);
        // Full is judged before the edge, so a same-cycle pop never rescues a push.
        push_s     = push_req_s && !full_s;
        drop_s     = push_req_s && full_s;
        pop_s      = !empty_s && bus.sram_grant &&
                     ((state_q == ST_IDLE) || (state_q == ST_HOLD));
        head_s     = mem_q[rd_ptr_q];
        lin_addr_s = 19'(head_s.y) * STRIDE + 19'(head_s.x);
    end

    // SRAM cycle sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pop_s) begin
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: state_d = ST_WRITE;
            ST_WRITE: state_d = ST_HOLD;
            ST_HOLD: begin
                if (pop_s) begin
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FIFO storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = '{fb: bus.fb_sel, x: bus.program_x,
                                y: bus.program_y, data: bus.program_data};
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Sticky overflow (a drop beats a simultaneous clear) and registered SRAM/status outputs.
    always_comb begin
        overflow_d    = overflow_q;
        sram_addr_d   = sram_addr_q;
        sram_dq_out_d = sram_dq_out_q;
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (bus.ovf_clear) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
        if (pop_s) begin
            sram_addr_d   = {head_s.fb, lin_addr_s};
            sram_dq_out_d = head_s.data;
        end else begin
            sram_addr_d   = sram_addr_q;
            sram_dq_out_d = sram_dq_out_q;
        end
        sram_we_n_d  = (state_d != ST_WRITE);
        sram_ce_n_d  = (state_d == ST_IDLE);
        sram_dq_oe_d = (state_d != ST_IDLE);
        fifo_full_d  = (count_d == DEPTH_C);
        busy_d       = (count_d != CNT_ZERO) || (state_d != ST_IDLE);
    end

    // State registers; reset forces the SRAM bus idle immediately.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q       <= ST_IDLE;
            count_q       <= CNT_ZERO;
            wr_ptr_q      <= PTR_ZERO;
            rd_ptr_q      <= PTR_ZERO;
            overflow_q    <= 1'b0;
            sram_addr_q   <= 20'h00000;
            sram_dq_out_q <= 16'h0000;
            sram_we_n_q   <= 1'b1;
            sram_ce_n_q   <= 1'b1;
            sram_dq_oe_q  <= 1'b0;
            fifo_full_q   <= 1'b0;
            busy_q        <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= ENTRY_ZERO;
            end
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            overflow_q    <= overflow_d;
            sram_addr_q   <= sram_addr_d;
            sram_dq_out_q <= sram_dq_out_d;
            sram_we_n_q   <= sram_we_n_d;
            sram_ce_n_q   <= sram_ce_n_d;
            sram_dq_oe_q  <= sram_dq_oe_d;
            fifo_full_q   <= fifo_full_d;
            busy_q        <= busy_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign bus.sram_addr   = sram_addr_q;
    assign bus.sram_dq_out = sram_dq_out_q;
    assign bus.sram_we_n   = sram_we_n_q;
    assign bus.sram_ce_n   = sram_ce_n_q;
    assign bus.sram_dq_oe  = sram_dq_oe_q;
    assign bus.fifo_full   = fifo_full_q;
    assign bus.overflow    = overflow_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_fb_write_stage.sv
// Self-checking bench for fb_write_stage: directed vectors, corner sequences
// and random traffic against a queue-based reference model.
module tb_fb_write_stage;

    localparam int DEPTH = 8;
    localparam int W     = 640;
    localparam int H     = 480;
`ifdef FB_TRANSPARENCY_EN
    localparam bit TRANSP = 1'b1;
`else
    localparam bit TRANSP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fb_write_if bus();

    fb_write_stage #(.FIFO_DEPTH(DEPTH), .FB_WIDTH(W), .FB_HEIGHT(H)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .bus           (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int edge_no  = 0;

    typedef struct {
        logic [19:0] addr;
        logic [15:0] data;
    } wr_t;

    // Reference model: pending writes, cycles since last pop, sticky overflow.
    wr_t         mq[$];
    int          since;
    bit          m_ovf;
    logic [19:0] m_addr;
    logic [15:0] m_data;

    int          we_edges[$];
    logic [15:0] we_data[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        since  = 100;
        m_ovf  = 1'b0;
        m_addr = 20'h0;
        m_data = 16'h0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we_n"},  bus.sram_we_n,   1);
        check({tag, "_ce_n"},  bus.sram_ce_n,   1);
        check({tag, "_oe"},    bus.sram_dq_oe,  0);
        check({tag, "_addr"},  bus.sram_addr,   0);
        check({tag, "_dq"},    bus.sram_dq_out, 0);
        check({tag, "_full"},  bus.fifo_full,   0);
        check({tag, "_ovf"},   bus.overflow,    0);
        check({tag, "_busy"},  bus.busy,        0);
    endtask

    // One clock: advance the model with the pre-edge inputs, then compare all outputs.
    task automatic tick();
        bit  req, full, pop;
        wr_t w;
        req  = bus.program_write && (bus.program_x < W) && (bus.program_y < H) &&
               !(TRANSP && bus.program_data == 16'hF81F);
        full = (mq.size() == DEPTH);
        pop  = (mq.size() > 0) && bus.sram_grant && (since >= 3);
        if (req && full) m_ovf = 1'b1;
        else if (bus.ovf_clear) m_ovf = 1'b0;
        if (pop) begin
            w      = mq.pop_front();
            m_addr = w.addr;
            m_data = w.data;
            since  = 1;
        end else if (since < 100) begin
            since++;
        end
        if (req && !full) begin
            w.addr = (bus.fb_sel ? 20'h80000 : 20'h00000) + 20'(bus.program_y * W + bus.program_x);
            w.data = bus.program_data;
            mq.push_back(w);
        end
        @(posedge clk);
        #1;
        edge_no++;
        if (bus.sram_we_n === 1'b0) begin
            we_edges.push_back(edge_no);
            we_data.push_back(bus.sram_dq_out);
        end
        check("sram_addr",   bus.sram_addr,   m_addr);
        check("sram_dq_out", bus.sram_dq_out, m_data);
        check("sram_we_n",   bus.sram_we_n,   (since == 2) ? 1'b0 : 1'b1);
        check("sram_ce_n",   bus.sram_ce_n,   (since > 3) ? 1'b1 : 1'b0);
        check("sram_dq_oe",  bus.sram_dq_oe,  (since <= 3) ? 1'b1 : 1'b0);
        check("fifo_full",   bus.fifo_full,   (mq.size() == DEPTH) ? 1'b1 : 1'b0);
        check("overflow",    bus.overflow,    m_ovf);
        check("busy",        bus.busy,        ((mq.size() > 0) || (since <= 3)) ? 1'b1 : 1'b0);
    endtask

    task automatic write_px(input logic [9:0] x, input logic [9:0] y,
                            input logic [15:0] d, input logic fb);
        bus.program_x     = x;
        bus.program_y     = y;
        bus.program_data  = d;
        bus.fb_sel        = fb;
        bus.program_write = 1'b1;
        tick();
        bus.program_write = 1'b0;
    endtask

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [15:0] data;
        logic        fb;
        bit          exp_wr;
        logic [19:0] exp_addr;
    } vec_t;

    vec_t vt[7];

    initial begin
        int first, cnt, guard;
        logic [19:0] cap_addr;
        logic [15:0] cap_data;

        vt[0] = '{x: 10'd3,   y: 10'd2,   data: 16'h1234, fb: 1'b0, exp_wr: 1'b1, exp_addr: 20'h00503};
        vt[1] = '{x: 10'd639, y: 10'd479, data: 16'hABCD, fb: 1'b1, exp_wr: 1'b1, exp_addr: 20'hCAFFF};
        vt[2] = '{x: 10'd640, y: 10'd0,   data: 16'h5A5A, fb: 1'b0, exp_wr: 1'b0, exp_addr: 20'h00000};
        vt[3] = '{x: 10'd0,   y: 10'd480, data: 16'h0F0F, fb: 1'b1, exp_wr: 1'b0, exp_addr: 20'h00000};
        vt[4] = '{x: 10'd5,   y: 10'd0,   data: 16'hF81F, fb: 1'b0, exp_wr: !TRANSP, exp_addr: 20'h00005};
        vt[5] = '{x: 10'd639, y: 10'd0,   data: 16'h5555, fb: 1'b0, exp_wr: 1'b1, exp_addr: 20'h0027F};
        vt[6] = '{x: 10'd0,   y: 10'd479, data: 16'h0001, fb: 1'b1, exp_wr: 1'b1, exp_addr: 20'hCAD80};

        bus.program_x = 10'd0; bus.program_y = 10'd0; bus.program_data = 16'h0;
        bus.program_write = 1'b0; bus.fb_sel = 1'b0; bus.sram_grant = 1'b0; bus.ovf_clear = 1'b0;
        model_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed single writes with timing of the write strobe.
        bus.sram_grant = 1'b1;
        for (int i = 0; i < 7; i++) begin
            repeat (2) tick();
            write_px(vt[i].x, vt[i].y, vt[i].data, vt[i].fb);
            first = -1; cnt = 0; cap_addr = 20'h0; cap_data = 16'h0;
            for (int k = 1; k <= 6; k++) begin
                tick();
                if (bus.sram_we_n === 1'b0) begin
                    cnt++;
                    if (first < 0) first = k;
                    cap_addr = bus.sram_addr;
                    cap_data = bus.sram_dq_out;
                end
            end
            check($sformatf("vec%0d_we_cycles", i), cnt, vt[i].exp_wr ? 1 : 0);
            check($sformatf("vec%0d_overflow", i), bus.overflow, 0);
            if (vt[i].exp_wr) begin
                check($sformatf("vec%0d_we_latency", i), first, 2);
                check($sformatf("vec%0d_addr", i), cap_addr, vt[i].exp_addr);
                check($sformatf("vec%0d_data", i), cap_data, vt[i].data);
            end
        end

        // Fill with grant low, overflow on the 9th, clear vs drop priority, then drain.
        repeat (4) tick();
        bus.sram_grant = 1'b0;
        we_edges.delete(); we_data.delete();
        for (int i = 0; i < 9; i++) begin
            write_px(10'(i), 10'd10, 16'h0100 + 16'(i), 1'b0);
            if (i == 7) begin
                check("fill_full_after8", bus.fifo_full, 1);
                check("fill_ovf_after8", bus.overflow, 0);
            end
        end
        check("fill_ovf_after9", bus.overflow, 1);
        bus.ovf_clear = 1'b1;
        write_px(10'd20, 10'd10, 16'hDEAD, 1'b0);
        bus.ovf_clear = 1'b0;
        check("ovf_clear_vs_drop", bus.overflow, 1);
        bus.ovf_clear = 1'b1;
        tick();
        bus.ovf_clear = 1'b0;
        check("ovf_clear_alone", bus.overflow, 0);
        check("no_sram_while_blocked", we_edges.size(), 0);
        bus.sram_grant = 1'b1;
        repeat (40) tick();
        check("drain_count", we_edges.size(), 8);
        for (int i = 0; i < 8 && i < we_edges.size(); i++) begin
            check($sformatf("drain_order%0d", i), we_data[i], 16'h0100 + 16'(i));
            if (i > 0) check($sformatf("drain_spacing%0d", i), we_edges[i] - we_edges[i-1], 3);
        end

        // Reset in the middle of a write strobe with entries still queued.
        write_px(10'd1, 10'd1, 16'h1111, 1'b0);
        write_px(10'd2, 10'd1, 16'h2222, 1'b0);
        write_px(10'd3, 10'd1, 16'h3333, 1'b1);
        guard = 0;
        while (bus.sram_we_n !== 1'b0 && guard < 20) begin
            tick();
            guard++;
        end
        check("wait_we_low", bus.sram_we_n, 0);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midwrite_reset");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        we_edges.delete(); we_data.delete();
        repeat (10) tick();
        check("no_write_after_reset", we_edges.size(), 0);
        write_px(10'd7, 10'd7, 16'h7777, 1'b0);
        repeat (5) tick();
        check("write_after_reset", we_edges.size(), 1);

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            bus.program_write = ($urandom_range(0, 9) < 6);
            bus.program_x     = 10'($urandom_range(0, 700));
            bus.program_y     = 10'($urandom_range(0, 520));
            bus.program_data  = ($urandom_range(0, 9) == 0) ? 16'hF81F : 16'($urandom);
            bus.fb_sel        = 1'($urandom_range(0, 1));
            bus.sram_grant    = ($urandom_range(0, 9) < 6);
            bus.ovf_clear     = ($urandom_range(0, 19) == 0);
            tick();
        end
        bus.program_write = 1'b0;
        bus.ovf_clear     = 1'b0;
        bus.sram_grant    = 1'b1;
        repeat (40) tick();
        check("final_idle_busy", bus.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
